// File: rtl/multicycle_sequencer_if.sv
// Control bundle between the multicycle step sequencer and the datapath.
// The slave modport is the sequencer side; the master modport is the
// side that supplies run/opcode/mem_ready and consumes the control strobes.
interface multicycle_sequencer_if;
  logic       run;
  logic [5:0] opcode;
  logic       mem_ready;
  logic [3:0] cont;
  logic       busy;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       pc_write;
  logic       pc_write_cond;
  logic       reg_write;
  logic       memtoreg;
  logic       reg_dst;
  logic       alu_src;
  logic [1:0] alu_op;
  logic       instr_done;
  logic       illegal;

  modport slave (
    input  run, opcode, mem_ready,
    output cont, busy, mem_read, mem_write, ir_write, pc_write, pc_write_cond,
           reg_write, memtoreg, reg_dst, alu_src, alu_op, instr_done, illegal
  );

  modport master (
    output run, opcode, mem_ready,
    input  cont, busy, mem_read, mem_write, ir_write, pc_write, pc_write_cond,
           reg_write, memtoreg, reg_dst, alu_src, alu_op, instr_done, illegal
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Step sequencer / control unit for the multicycle MIPS datapath.
// Produces the step count `cont` and decodes the latched opcode into
// per-step datapath strobes. Outputs are combinational decodes of the
// registered state, step count and latched opcode.
// Optional build macro SEQ_STALL_EN: adds a WAIT_MEM state that holds the
// fetch step (cont 0) and the LW/SW memory step (cont 8) until mem_ready.
module multicycle_sequencer #(
  parameter int unsigned LAST_FETCH = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  multicycle_sequencer_if.slave bus
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [3:0] FETCH_STEP = 4'(LAST_FETCH);

`ifdef SEQ_STALL_EN
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    WAIT_MEM = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1
  } state_t;
`endif

  state_t     state_q, state_d;
  logic [3:0] cont_q, cont_d;
  logic [5:0] op_q, op_d;

  logic is_r_s, is_lw_s, is_sw_s, is_beq_s, is_j_s, is_addi_s, legal_s;
  logic active_s, in_body_s, end_s, mem_ok_s;

  logic       mem_read_s, mem_write_s, ir_write_s, pc_write_s, pc_write_cond_s;
  logic       reg_write_s, memtoreg_s, reg_dst_s, alu_src_s;
  logic [1:0] alu_op_s;
  logic       instr_done_s, illegal_s;

  assign is_r_s    = (op_q == OP_R);
  assign is_lw_s   = (op_q == OP_LW);
  assign is_sw_s   = (op_q == OP_SW);
  assign is_beq_s  = (op_q == OP_BEQ);
  assign is_j_s    = (op_q == OP_J);
  assign is_addi_s = (op_q == OP_ADDI);
  assign legal_s   = is_r_s | is_lw_s | is_sw_s | is_beq_s | is_j_s | is_addi_s;

  assign active_s  = (state_q != IDLE);
  // Opcode-dependent selects are only meaningful once op_q holds this instruction.
  assign in_body_s = active_s && (cont_q >= 4'd3);

`ifdef SEQ_STALL_EN
  logic stall_pt_s;
  assign stall_pt_s = (cont_q == 4'd0) || ((cont_q == 4'd8) && (is_lw_s || is_sw_s));
  assign mem_ok_s   = !stall_pt_s || bus.mem_ready;
`else
  logic unused_mem_ready_s;
  assign unused_mem_ready_s = bus.mem_ready;
  assign mem_ok_s           = 1'b1;
`endif

  // Decide whether the current step is the final step of the instruction.
  always_comb begin
    end_s = 1'b0;
    case (cont_q)
      4'd3:    end_s = !legal_s;
      4'd4:    end_s = is_beq_s || is_j_s;
      4'd7:    end_s = is_r_s || is_addi_s;
      4'd8:    end_s = is_sw_s;
      4'd9:    end_s = 1'b1;  // last possible step; cont never passes 9
      default: end_s = 1'b0;
    endcase
  end

  // State, step counter and latched opcode registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cont_q  <= 4'd0;
      op_q    <= 6'd0;
    end else begin
      state_q <= state_d;
      cont_q  <= cont_d;
      op_q    <= op_d;
    end
  end

  // Next-state and next-step logic.
  always_comb begin
    state_d = state_q;
    cont_d  = cont_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        cont_d = 4'd0;
        if (bus.run) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
`ifdef SEQ_STALL_EN
      RUN, WAIT_MEM: begin
`else
      RUN: begin
`endif
        if (cont_q == 4'd2) begin
          op_d = bus.opcode;
        end else begin
          op_d = op_q;
        end
        if (!mem_ok_s) begin
`ifdef SEQ_STALL_EN
          state_d = WAIT_MEM;
`else
          state_d = RUN;
`endif
          cont_d = cont_q;
        end else if (end_s) begin
          cont_d = 4'd0;
          if (bus.run) begin
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cont_d  = cont_q + 4'd1;
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        cont_d  = 4'd0;
      end
    endcase
  end

  // Per-step strobe and mux-select decode.
  always_comb begin
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    ir_write_s      = 1'b0;
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    reg_write_s     = 1'b0;
    illegal_s       = 1'b0;
    if (active_s) begin
      if (cont_q == FETCH_STEP) begin
        ir_write_s = 1'b1;
        pc_write_s = 1'b1;
      end else begin
        ir_write_s = 1'b0;
      end
      case (cont_q)
        4'd0: mem_read_s = 1'b1;
        4'd3: illegal_s  = !legal_s;
        4'd4: begin
          pc_write_cond_s = is_beq_s;
          pc_write_s      = pc_write_s || is_j_s;
        end
        4'd7: reg_write_s = is_r_s || is_addi_s;
        4'd8: begin
          mem_read_s  = is_lw_s;
          mem_write_s = is_sw_s;
        end
        4'd9:    reg_write_s = is_lw_s;
        default: mem_read_s  = 1'b0;
      endcase
    end else begin
      mem_read_s = 1'b0;
    end

    memtoreg_s = in_body_s && is_lw_s;
    reg_dst_s  = in_body_s && is_r_s;
    alu_src_s  = in_body_s && (is_lw_s || is_sw_s || is_addi_s);
    if (in_body_s && is_r_s) begin
      alu_op_s = 2'b10;
    end else if (in_body_s && is_beq_s) begin
      alu_op_s = 2'b01;
    end else begin
      alu_op_s = 2'b00;
    end

    instr_done_s = active_s && end_s && mem_ok_s;
  end

  assign bus.cont          = cont_q;
  assign bus.busy          = active_s;
  assign bus.mem_read      = mem_read_s;
  assign bus.mem_write     = mem_write_s;
  assign bus.ir_write      = ir_write_s;
  assign bus.pc_write      = pc_write_s;
  assign bus.pc_write_cond = pc_write_cond_s;
  assign bus.reg_write     = reg_write_s;
  assign bus.memtoreg      = memtoreg_s;
  assign bus.reg_dst       = reg_dst_s;
  assign bus.alu_src       = alu_src_s;
  assign bus.alu_op        = alu_op_s;
  assign bus.instr_done    = instr_done_s;
  assign bus.illegal       = illegal_s;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: a per-cycle vector table
// covering every instruction class, plus hand-written reset and stall sequences.
module tb_multicycle_sequencer;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  // Packed observation: {busy, mem_read, mem_write, ir_write, pc_write,
  // pc_write_cond, reg_write, memtoreg, reg_dst, alu_src, alu_op[1:0],
  // instr_done, illegal}
  localparam logic [13:0] BSY  = 14'h2000;
  localparam logic [13:0] MRD  = 14'h1000;
  localparam logic [13:0] MWR  = 14'h0800;
  localparam logic [13:0] IRW  = 14'h0400;
  localparam logic [13:0] PCW  = 14'h0200;
  localparam logic [13:0] PCC  = 14'h0100;
  localparam logic [13:0] RGW  = 14'h0080;
  localparam logic [13:0] MTR  = 14'h0040;
  localparam logic [13:0] RDS  = 14'h0020;
  localparam logic [13:0] ASR  = 14'h0010;
  localparam logic [13:0] AOPF = 14'h0008;
  localparam logic [13:0] AOPS = 14'h0004;
  localparam logic [13:0] DON  = 14'h0002;
  localparam logic [13:0] ILL  = 14'h0001;
  localparam logic [13:0] FET0 = BSY | MRD;
  localparam logic [13:0] FET1 = BSY | IRW | PCW;

  typedef struct {
    logic        run;
    logic [5:0]  opcode;
    logic [3:0]  exp_cont;
    logic [13:0] exp_sig;
  } vec_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  multicycle_sequencer_if bus ();

  multicycle_sequencer #(.LAST_FETCH(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [13:0] sig_s;
  assign sig_s = {bus.busy, bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write,
                  bus.pc_write_cond, bus.reg_write, bus.memtoreg, bus.reg_dst,
                  bus.alu_src, bus.alu_op, bus.instr_done, bus.illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic run, input logic [5:0] op,
                              input logic [3:0] c, input logic [13:0] s);
    vec_t v;
    v.run      = run;
    v.opcode   = op;
    v.exp_cont = c;
    v.exp_sig  = s;
    return v;
  endfunction

  // Advance to the next negedge (+1) until cont reaches target while busy, bounded.
  task automatic wait_cont(input logic [3:0] target, input string name);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (bus.busy && bus.cont == target) break;
    end
    check(name, {28'd0, bus.cont}, {28'd0, target});
  endtask

  vec_t vq[$];

  initial begin
    tests         = 0;
    fails         = 0;
    rst_n         = 1'b0;
    bus.run       = 1'b0;
    bus.opcode    = 6'd0;
    bus.mem_ready = 1'b1;

    // R-type, back-to-back LW, BEQ, J, illegal, ADDI
    vq.push_back(mk(1'b1, OP_R, 4'd0, 14'h0));  // still IDLE before first edge
    vq.push_back(mk(1'b1, OP_R, 4'd0, FET0));
    vq.push_back(mk(1'b1, OP_R, 4'd1, FET1));
    vq.push_back(mk(1'b1, OP_R, 4'd2, BSY));
    for (int c = 3; c <= 6; c++) vq.push_back(mk(1'b1, OP_R, 4'(c), BSY | RDS | AOPF));
    vq.push_back(mk(1'b1, OP_R, 4'd7, BSY | RDS | AOPF | RGW | DON));
    vq.push_back(mk(1'b1, OP_LW, 4'd0, FET0));
    vq.push_back(mk(1'b1, OP_LW, 4'd1, FET1));
    vq.push_back(mk(1'b1, OP_LW, 4'd2, BSY));
    for (int c = 3; c <= 7; c++) vq.push_back(mk(1'b1, OP_LW, 4'(c), BSY | MTR | ASR));
    vq.push_back(mk(1'b1, OP_LW, 4'd8, BSY | MTR | ASR | MRD));
    vq.push_back(mk(1'b1, OP_LW, 4'd9, BSY | MTR | ASR | RGW | DON));
    vq.push_back(mk(1'b1, OP_BEQ, 4'd0, FET0));
    vq.push_back(mk(1'b1, OP_BEQ, 4'd1, FET1));
    vq.push_back(mk(1'b1, OP_BEQ, 4'd2, BSY));
    vq.push_back(mk(1'b1, OP_BEQ, 4'd3, BSY | AOPS));
    vq.push_back(mk(1'b1, OP_BEQ, 4'd4, BSY | AOPS | PCC | DON));
    vq.push_back(mk(1'b1, OP_J, 4'd0, FET0));
    vq.push_back(mk(1'b1, OP_J, 4'd1, FET1));
    vq.push_back(mk(1'b1, OP_J, 4'd2, BSY));
    vq.push_back(mk(1'b1, OP_J, 4'd3, BSY));
    vq.push_back(mk(1'b1, OP_J, 4'd4, BSY | PCW | DON));
    vq.push_back(mk(1'b1, OP_BAD, 4'd0, FET0));
    vq.push_back(mk(1'b1, OP_BAD, 4'd1, FET1));
    vq.push_back(mk(1'b1, OP_BAD, 4'd2, BSY));
    vq.push_back(mk(1'b1, OP_BAD, 4'd3, BSY | ILL | DON));
    vq.push_back(mk(1'b1, OP_ADDI, 4'd0, FET0));
    vq.push_back(mk(1'b1, OP_ADDI, 4'd1, FET1));
    vq.push_back(mk(1'b1, OP_ADDI, 4'd2, BSY));
    for (int c = 3; c <= 6; c++) vq.push_back(mk(1'b1, OP_ADDI, 4'(c), BSY | ASR));
    vq.push_back(mk(1'b1, OP_ADDI, 4'd7, BSY | ASR | RGW | DON));
    // SW with run dropped at cont 2: instruction completes, then IDLE
    vq.push_back(mk(1'b1, OP_SW, 4'd0, FET0));
    vq.push_back(mk(1'b1, OP_SW, 4'd1, FET1));
    vq.push_back(mk(1'b0, OP_SW, 4'd2, BSY));
    for (int c = 3; c <= 7; c++) vq.push_back(mk(1'b0, OP_SW, 4'(c), BSY | ASR));
    vq.push_back(mk(1'b0, OP_SW, 4'd8, BSY | ASR | MWR | DON));
    vq.push_back(mk(1'b0, OP_SW, 4'd0, 14'h0));
    vq.push_back(mk(1'b0, OP_SW, 4'd0, 14'h0));

    // Outputs during reset
    #1;
    check("reset_cont", {28'd0, bus.cont}, 32'd0);
    check("reset_sig", {18'd0, sig_s}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: inputs applied at negedge, outputs reflect the current state
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      bus.run    = vq[i].run;
      bus.opcode = vq[i].opcode;
      #1;
      check($sformatf("vec%0d_cont", i), {28'd0, bus.cont}, {28'd0, vq[i].exp_cont});
      check($sformatf("vec%0d_sig", i), {18'd0, sig_s}, {18'd0, vq[i].exp_sig});
    end

    // Reset asserted at SW cont 6 clears everything immediately
    bus.run    = 1'b1;
    bus.opcode = OP_SW;
    wait_cont(4'd6, "wait_sw_cont6");
    check("sw_cont6_sig", {18'd0, sig_s}, {18'd0, BSY | ASR});
    rst_n = 1'b0;
    #1;
    check("async_rst_cont", {28'd0, bus.cont}, 32'd0);
    check("async_rst_sig", {18'd0, sig_s}, 32'd0);
    @(negedge clk);
    #1;
    check("held_rst_sig", {18'd0, sig_s}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("restart_cont0", {28'd0, bus.cont}, 32'd0);
    check("restart_fetch", {18'd0, sig_s}, {18'd0, FET0});
    @(negedge clk);
    #1;
    check("restart_cont1", {28'd0, bus.cont}, 32'd1);
    check("restart_irw", {18'd0, sig_s}, {18'd0, FET1});

`ifdef SEQ_STALL_EN
    // SW memory step stalled for 3 cycles
    wait_cont(4'd8, "wait_sw_cont8");
    bus.mem_ready = 1'b0;
    #1;
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) begin
        @(negedge clk);
        #1;
      end
      check($sformatf("stall%0d_cont", k), {28'd0, bus.cont}, 32'd8);
      check($sformatf("stall%0d_sig", k), {18'd0, sig_s}, {18'd0, BSY | ASR | MWR});
    end
    @(negedge clk);
    bus.mem_ready = 1'b1;
    #1;
    check("stall4_cont", {28'd0, bus.cont}, 32'd8);
    check("stall4_sig", {18'd0, sig_s}, {18'd0, BSY | ASR | MWR | DON});
    @(negedge clk);
    #1;
    check("after_stall_cont", {28'd0, bus.cont}, 32'd0);
    check("after_stall_fetch", {18'd0, sig_s}, {18'd0, FET0});
`endif

    // Drop run and let the current instruction drain to IDLE
    bus.run = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (!bus.busy) break;
    end
    check("drain_idle_sig", {18'd0, sig_s}, 32'd0);
    check("drain_idle_cont", {28'd0, bus.cont}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Step sequencer and control unit for the multicycle MIPS datapath. It produces the 4-bit step count `cont` that datapath blocks (the memtoreg writeback mux, PC, IR, register file, ALU, memory) use to qualify their updates. It also decodes the latched opcode into per-step control strobes, so that each instruction class finishes on a fixed step: R-type/ADDI write back at cont 7, LW at cont 9. It sits between the instruction register and every control input of the datapath.

## Interface
Parameters:
- `LAST_FETCH`, 1: step at which the IR is written and PC+4 is committed.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; high = keep issuing instructions.
- `opcode`  in  6  IR[31:26]; sampled at cont 2.
- `mem_ready`  in  1  memory handshake (used only with `SEQ_STALL_EN`).
- `cont`  out  4  current step within the instruction.
- `busy`  out  1  high while not in IDLE.
- `mem_read`, `mem_write`, `ir_write`, `pc_write`, `pc_write_cond`, `reg_write`  out  1 each  datapath strobes.
- `memtoreg`, `reg_dst`, `alu_src`  out  1 each  mux selects.
- `alu_op`  out  2  00 add, 01 sub, 10 use funct.
- `instr_done`  out  1  one-cycle pulse on the final step of the instruction.
- `illegal`  out  1  one-cycle pulse on cont 3 for an unsupported opcode.

## Operation
- FSM states: IDLE, RUN, WAIT_MEM (WAIT_MEM exists only with `SEQ_STALL_EN`).
- `cont` is a register. `op_q` holds the opcode, loaded at cont 2.
- Outputs are combinational decodes of state, `cont` and `op_q`.
- Supported opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, J 000010, ADDI 001000.
- Step schedule (RUN):
  - cont 0: `mem_read`=1 (fetch).
  - cont 1: `ir_write`=1, `pc_write`=1.
  - cont 2: latch `op_q` from `opcode`.
  - cont 3: unsupported opcode -> `illegal`=1, `instr_done`=1, instruction ends.
  - cont 4: BEQ -> `pc_write_cond`=1, ends. J -> `pc_write`=1, ends.
  - cont 5–6: execute and ALU result register; no strobes.
  - cont 7: R/ADDI -> `reg_write`=1, ends. LW/SW -> address is ready.
  - cont 8: LW -> `mem_read`=1. SW -> `mem_write`=1, ends.
  - cont 9: LW -> `reg_write`=1, ends.
- Control selects:
  - `memtoreg` = (`op_q`==LW) from cont 3 to the end of the instruction, else 0.
  - `reg_dst`=1 for R.
  - `alu_src`=1 for LW/SW/ADDI.
  - `alu_op`: 10 for R, 01 for BEQ, 00 otherwise. Valid cont 3 to the end; 00 outside that range.
- End of instruction: next `cont`=0. State stays RUN if `run`=1, otherwise goes to IDLE.
- IDLE: `cont`=0, all strobes 0. `run`=1 -> RUN at the next edge with cont 0.
- Deasserting `run` mid-instruction: the instruction completes, then the FSM enters IDLE.

## Timing
- Reset (async, immediate): state IDLE, `cont`=0, `op_q`=0. All strobes, `busy`, `instr_done` and `illegal` are 0.
- Reset mid-instruction aborts it; no strobe is asserted during or after reset.
- `cont` increments by 1 per cycle in RUN. Maximum value is 9; it never wraps beyond 9.
- Instruction latency in cycles: J/BEQ 5, R/ADDI 8, SW 9, LW 10, illegal 4.
- `run`=1 continuously gives back-to-back instructions: the cycle after `instr_done` is cont 0 of the next instruction.
- `opcode` must be stable at the cont 2 edge; changes at other times are ignored.

## Configuration
- `SEQ_STALL_EN` defined: at cont 0, and at cont 8 for LW/SW, the FSM enters WAIT_MEM while `mem_ready`=0.
  - `cont` and the active strobe are held.
  - The FSM advances on the first edge that samples `mem_ready`=1.
  - `mem_ready` already 1 adds zero cycles.
- `SEQ_STALL_EN` undefined: `mem_ready` is ignored, there is no WAIT_MEM state, and memory is assumed single-cycle.

## Test plan
- Reset held, then `run`=1 with R-type -> `cont` goes 0..7. `reg_write`=1 and `memtoreg`=0 only at cont 7, `instr_done` at cont 7, next cycle cont 0.
- LW (100011) -> `mem_read` at cont 0 and 8. `memtoreg`=1 from cont 3. `reg_write` at cont 9 only. 10 cycles total.
- BEQ then J back-to-back -> `pc_write_cond` at the BEQ cont 4 and `pc_write` at the J cont 4. Each takes 5 cycles; `alu_op`=01 for BEQ.
- Opcode 111111 -> `illegal` and `instr_done` pulse at cont 3, no `reg_write` or `mem_write`. `run` drops mid-LW -> LW finishes at cont 9, then IDLE with `busy`=0.
- `rst_n` low at SW cont 6 -> outputs 0 immediately. After release with `run`=1, fetch restarts at cont 0.
- With `SEQ_STALL_EN`: SW with `mem_ready`=0 for 3 cycles at cont 8 -> `mem_write` held 4 cycles, `cont` stays 8, `instr_done` on the 4th cycle.
